// File: rtl/uart_peak_finder.sv
// uart_peak_finder
//
// Parses framed sample streams arriving from a UART receiver and reports the
// largest unsigned 16-bit sample of each good frame together with its position.
//
// Frame layout (one byte per rx_en strobe):
//   0x55 | N | N x {MSB, LSB} | [checksum]
// The checksum byte is only expected when UART_PEAK_CHECKSUM_EN is defined; it is
// the XOR of the count byte and all 2N sample bytes. The default build (macro
// undefined) has no checksum state or accumulator and completes after the final LSB.
//
// Ports:
//   clk         system clock, rising edge
//   rstn        synchronous active-low reset
//   rx_data     received byte, qualified by rx_en
//   rx_en       one-cycle byte strobe, no backpressure
//   peak_value  largest sample of the last good frame (holds between frames)
//   peak_index  zero-based index of that sample
//   peak_valid  one-cycle pulse when peak_value/peak_index are updated
//   frame_err   one-cycle pulse when a frame is discarded (N=0, checksum, timeout)
//   busy        high whenever a frame is in progress (state other than S_HDR)
//
// Parameter:
//   TIMEOUT_CYCLES  idle clocks tolerated between bytes inside a frame (>= 1)

module uart_peak_finder #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [7:0]  rx_data,
    input  logic        rx_en,
    output logic [15:0] peak_value,
    output logic [7:0]  peak_index,
    output logic        peak_valid,
    output logic        frame_err,
    output logic        busy
);

    // The idle counter only needs to hold 0 .. TIMEOUT_CYCLES-1: the clock that would
    // take it to TIMEOUT_CYCLES is the clock that fires the timeout instead.
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]      HdrByte     = 8'h55;

`ifdef UART_PEAK_CHECKSUM_EN
    typedef enum logic [2:0] {S_HDR, S_LEN, S_MSB, S_LSB, S_CHK} state_e;
`else
    typedef enum logic [2:0] {S_HDR, S_LEN, S_MSB, S_LSB} state_e;
`endif

    state_e          state_q;
    logic [7:0]      len_q;
    logic [7:0]      idx_q;
    logic [7:0]      msb_q;
    logic [15:0]     work_value_q;
    logic [7:0]      work_index_q;
    logic [CntW-1:0] idle_q;
`ifdef UART_PEAK_CHECKSUM_EN
    logic [7:0]      chk_q;
`endif

    logic [15:0]     peak_value_q;
    logic [7:0]      peak_index_q;
    logic            peak_valid_q;
    logic            frame_err_q;

    // Candidate peak after folding in the sample completed by the current LSB byte.
    logic [15:0]     sample;
    logic            take_sample;
    logic [15:0]     cand_value;
    logic [7:0]      cand_index;
    logic            last_sample;

    always_comb begin
        sample      = {msb_q, rx_data};
        // Strict compare keeps the first of equal maxima; index 0 always seeds the peak.
        take_sample = (idx_q == 8'd0) || (sample > work_value_q);
        cand_value  = take_sample ? sample : work_value_q;
        cand_index  = take_sample ? idx_q : work_index_q;
        last_sample = (idx_q == (len_q - 8'd1));
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_HDR;
            len_q        <= 8'd0;
            idx_q        <= 8'd0;
            msb_q        <= 8'd0;
            work_value_q <= 16'd0;
            work_index_q <= 8'd0;
            idle_q       <= '0;
`ifdef UART_PEAK_CHECKSUM_EN
            chk_q        <= 8'd0;
`endif
            peak_value_q <= 16'd0;
            peak_index_q <= 8'd0;
            peak_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            peak_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;

            // A byte always wins over a timeout landing on the same clock.
            if (rx_en) begin
                idle_q <= '0;
                unique case (state_q)
                    S_HDR: begin
                        // Anything but the header byte is line noise between frames.
                        if (rx_data == HdrByte) begin
                            state_q <= S_LEN;
                        end
                    end
                    S_LEN: begin
                        if (rx_data == 8'd0) begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_HDR;
                        end else begin
                            len_q        <= rx_data;
                            idx_q        <= 8'd0;
                            work_value_q <= 16'd0;
                            work_index_q <= 8'd0;
`ifdef UART_PEAK_CHECKSUM_EN
                            chk_q        <= rx_data;
`endif
                            state_q      <= S_MSB;
                        end
                    end
                    S_MSB: begin
                        msb_q   <= rx_data;
`ifdef UART_PEAK_CHECKSUM_EN
                        chk_q   <= chk_q ^ rx_data;
`endif
                        state_q <= S_LSB;
                    end
                    S_LSB: begin
                        work_value_q <= cand_value;
                        work_index_q <= cand_index;
`ifdef UART_PEAK_CHECKSUM_EN
                        chk_q        <= chk_q ^ rx_data;
`endif
                        if (last_sample) begin
`ifdef UART_PEAK_CHECKSUM_EN
                            state_q      <= S_CHK;
`else
                            peak_value_q <= cand_value;
                            peak_index_q <= cand_index;
                            peak_valid_q <= 1'b1;
                            state_q      <= S_HDR;
`endif
                        end else begin
                            idx_q   <= idx_q + 8'd1;
                            state_q <= S_MSB;
                        end
                    end
`ifdef UART_PEAK_CHECKSUM_EN
                    S_CHK: begin
                        if (rx_data == chk_q) begin
                            peak_value_q <= work_value_q;
                            peak_index_q <= work_index_q;
                            peak_valid_q <= 1'b1;
                        end else begin
                            frame_err_q  <= 1'b1;
                        end
                        state_q <= S_HDR;
                    end
`endif
                    default: begin
                        state_q <= S_HDR;
                    end
                endcase
            end else if (state_q != S_HDR) begin
                if (idle_q == TimeoutLast) begin
                    frame_err_q <= 1'b1;
                    idle_q      <= '0;
                    state_q     <= S_HDR;
                end else begin
                    idle_q <= idle_q + CntW'(1);
                end
            end else begin
                idle_q <= '0;
            end
        end
    end

    assign peak_value = peak_value_q;
    assign peak_index = peak_index_q;
    assign peak_valid = peak_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != S_HDR);

endmodule

// File: tb/tb_uart_peak_finder.sv
// Self-checking bench for uart_peak_finder (TIMEOUT_CYCLES = 100).
// Works for both builds; checksum bytes are sent only when UART_PEAK_CHECKSUM_EN
// is defined.

module tb_uart_peak_finder;

    logic        clk;
    logic        rstn;
    logic [7:0]  rx_data;
    logic        rx_en;
    logic [15:0] peak_value;
    logic [7:0]  peak_index;
    logic        peak_valid;
    logic        frame_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Pulse bookkeeping: what the bench expects versus what the monitor sees.
    int exp_pv   = 0;
    int exp_fe   = 0;
    int pv_cnt   = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;

    // Reference model state: outputs of the last good frame.
    logic [15:0] ref_value = 16'd0;
    logic [7:0]  ref_index = 8'd0;

    logic [15:0] samp_q[$];
    logic [7:0]  frame_q[$];

    uart_peak_finder #(
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx_data    (rx_data),
        .rx_en      (rx_en),
        .peak_value (peak_value),
        .peak_index (peak_index),
        .peak_valid (peak_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (peak_valid === 1'b1) pv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
        if (peak_valid === 1'b1 && frame_err === 1'b1) both_cnt++;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; byte is sampled on the next posedge, returns at the
    // following negedge where the registered response is visible.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap);
        repeat (gap) @(negedge clk);
        rx_data = b;
        rx_en   = 1'b1;
        @(negedge clk);
        rx_en   = 1'b0;
    endtask

    // Builds a frame from samp_q, sends it, and checks the outcome against the
    // arithmetic definition of the peak (first maximum wins).
    task automatic run_frame(input string tag, input bit corrupt, input int unsigned gap_max);
        logic [7:0]  chk;
        logic [15:0] best;
        logic [7:0]  best_i;
        bit          good;
        chk    = 8'(samp_q.size());
        best   = 16'd0;
        best_i = 8'd0;
        frame_q.delete();
        frame_q.push_back(8'h55);
        frame_q.push_back(8'(samp_q.size()));
        foreach (samp_q[i]) begin
            frame_q.push_back(samp_q[i][15:8]);
            frame_q.push_back(samp_q[i][7:0]);
            chk = chk ^ samp_q[i][15:8] ^ samp_q[i][7:0];
            if (i == 0 || samp_q[i] > best) begin
                best   = samp_q[i];
                best_i = 8'(i);
            end
        end
`ifdef UART_PEAK_CHECKSUM_EN
        frame_q.push_back(corrupt ? ~chk : chk);
        good = !corrupt;
`else
        good = 1'b1;
`endif
        if (good) begin
            ref_value = best;
            ref_index = best_i;
            exp_pv++;
        end else begin
            exp_fe++;
        end
        foreach (frame_q[i]) begin
            send_byte(frame_q[i], (i == 0) ? 0 : $urandom_range(0, gap_max));
        end
        check({tag, "_valid"}, {31'd0, peak_valid}, {31'd0, good});
        check({tag, "_err"},   {31'd0, frame_err},  {31'd0, !good});
        check({tag, "_value"}, {16'd0, peak_value}, {16'd0, ref_value});
        check({tag, "_index"}, {24'd0, peak_index}, {24'd0, ref_index});
        check({tag, "_busy"},  {31'd0, busy},       32'd0);
        @(negedge clk);
        check({tag, "_pulse_end"}, {30'd0, peak_valid, frame_err}, 32'd0);
    endtask

    initial begin
        rstn    = 1'b0;
        rx_en   = 1'b0;
        rx_data = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_value", {16'd0, peak_value}, 32'd0);
        check("rst_index", {24'd0, peak_index}, 32'd0);
        check("rst_valid", {31'd0, peak_valid}, 32'd0);
        check("rst_err",   {31'd0, frame_err},  32'd0);
        check("rst_busy",  {31'd0, busy},       32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Three samples, largest in the middle
        samp_q = '{16'h0010, 16'h0120, 16'h0005};
        run_frame("basic", 1'b0, 0);
        check("basic_const_value", {16'd0, peak_value}, 32'h0120);
        check("basic_const_index", {24'd0, peak_index}, 32'd1);

        // Tie: first occurrence wins
        samp_q = '{16'h0007, 16'h0007};
        run_frame("tie", 1'b0, 2);
        check("tie_const_index", {24'd0, peak_index}, 32'd0);
        check("tie_const_value", {16'd0, peak_value}, 32'h0007);

`ifdef UART_PEAK_CHECKSUM_EN
        // Bad checksum: outputs hold the tie frame result
        samp_q = '{16'h1234};
        run_frame("badchk", 1'b1, 0);
        check("badchk_hold", {16'd0, peak_value}, 32'h0007);
`endif

        // N = 0 then a normal frame
        send_byte(8'h55, 0);
        send_byte(8'h00, 0);
        exp_fe++;
        check("n0_err",  {31'd0, frame_err}, 32'd1);
        check("n0_busy", {31'd0, busy},      32'd0);
        @(negedge clk);
        check("n0_err_end", {31'd0, frame_err}, 32'd0);
        samp_q = '{16'h8000, 16'h7FFF, 16'h8001};
        run_frame("after_n0", 1'b0, 1);

        // Header bytes mid-frame are data
        samp_q = '{16'h5555, 16'h0055};
        run_frame("mid55", 1'b0, 0);

        // Noise while idle is ignored silently
        send_byte(8'hAA, 1);
        send_byte(8'h00, 0);
        send_byte(8'h54, 2);
        send_byte(8'hFF, 0);
        check("noise_busy", {31'd0, busy}, 32'd0);
        check("noise_err",  {31'd0, frame_err}, 32'd0);

        // Timeout exactly 100 clocks after the last byte
        send_byte(8'h55, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        repeat (99) @(negedge clk);
        check("to_before_err",  {31'd0, frame_err}, 32'd0);
        check("to_before_busy", {31'd0, busy},      32'd1);
        @(negedge clk);
        exp_fe++;
        check("to_err",  {31'd0, frame_err}, 32'd1);
        check("to_busy", {31'd0, busy},      32'd0);
        check("to_hold", {16'd0, peak_value}, {16'd0, ref_value});
        @(negedge clk);
        check("to_err_end", {31'd0, frame_err}, 32'd0);

        // Byte landing on clock 100 is processed; no timeout
        send_byte(8'h55, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        repeat (98) @(negedge clk);
        send_byte(8'h07, 1);
        check("late_err",  {31'd0, frame_err}, 32'd0);
        check("late_busy", {31'd0, busy},      32'd1);
        send_byte(8'h00, 0);
        send_byte(8'h09, 0);
`ifdef UART_PEAK_CHECKSUM_EN
        send_byte(8'h0C, 0);
`endif
        exp_pv++;
        ref_value = 16'h0009;
        ref_index = 8'd1;
        check("late_valid", {31'd0, peak_valid}, 32'd1);
        check("late_value", {16'd0, peak_value}, 32'h0009);
        check("late_index", {24'd0, peak_index}, 32'd1);
        @(negedge clk);

        // Reset mid-frame: everything clears, no pulse
        send_byte(8'h55, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        rstn = 1'b0;
        @(negedge clk);
        check("mrst_value", {16'd0, peak_value}, 32'd0);
        check("mrst_index", {24'd0, peak_index}, 32'd0);
        check("mrst_pulse", {30'd0, peak_valid, frame_err}, 32'd0);
        check("mrst_busy",  {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        ref_value = 16'd0;
        ref_index = 8'd0;
        @(negedge clk);
        samp_q = '{16'h0003, 16'h0100, 16'h00FF, 16'h0100};
        run_frame("after_mrst", 1'b0, 2);

        // Longest frame, peak at the last index
        samp_q.delete();
        for (int i = 0; i < 255; i++) samp_q.push_back(16'(i * 3));
        run_frame("long", 1'b0, 0);
        check("long_index", {24'd0, peak_index}, 32'd254);

        // Randomized frames with gaps, ties and occasional corrupted checksums
        for (int k = 0; k < 24; k++) begin
            int unsigned n;
            bit          corrupt;
            samp_q.delete();
            n = $urandom_range(1, 10);
            for (int j = 0; j < int'(n); j++) begin
                if ($urandom_range(0, 2) == 0) samp_q.push_back(16'($urandom_range(0, 3)));
                else samp_q.push_back(16'($urandom));
            end
            corrupt = ($urandom_range(0, 3) == 0);
            run_frame($sformatf("rand%0d", k), corrupt, 3);
        end

        @(negedge clk);
        check("pv_count", 32'(pv_cnt), 32'(exp_pv));
        check("fe_count", 32'(fe_cnt), 32'(exp_fe));
        check("no_overlap", 32'(both_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
